// File: rtl/skein_nonce_scheduler_if.sv
// Work-offer and found-nonce channels between the work distributor and the nonce scheduler.
// The master modport is the distributor side; the slave modport is the scheduler.
interface skein_nonce_scheduler_if;
  logic         work_valid;
  logic         work_ready;
  logic [511:0] work_midstate;
  logic [95:0]  work_data;
  logic [31:0]  work_nonce_start;
  logic [31:0]  work_nonce_count;
  logic [31:0]  work_target;
  logic         found_valid;
  logic         found_ready;
  logic [31:0]  found_nonce;

  modport master (
    output work_valid, work_midstate, work_data, work_nonce_start, work_nonce_count, work_target,
    input  work_ready,
    input  found_valid, found_nonce,
    output found_ready
  );

  modport slave (
    input  work_valid, work_midstate, work_data, work_nonce_start, work_nonce_count, work_target,
    output work_ready,
    output found_valid, found_nonce,
    input  found_ready
  );
endinterface

// File: rtl/skein_nonce_scheduler.sv
// Feeds one work unit's nonce range into the pipelined skein512 core, follows each nonce
// through the pipe with a tag bit, and queues nonces whose hash meets the target.
module skein_nonce_scheduler #(
  parameter int unsigned PIPE_LATENCY   = 184,
  parameter int unsigned ISSUE_INTERVAL = 2,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  skein_nonce_scheduler_if.slave   bus,
  input  logic                     abort,
  output logic [511:0]             core_midstate,
  output logic [95:0]              core_data,
  output logic [31:0]              core_nonce,
  input  logic [511:0]             core_hash,
  output logic [15:0]              found_dropped,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned PW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam int unsigned IW = $clog2(PIPE_LATENCY + 2);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PhaseLast = PW'(ISSUE_INTERVAL - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [511:0]           mid_q;
  logic [95:0]            data_q;
  logic [31:0]            target_q;
  logic [31:0]            issue_nonce_q, issue_nonce_d;
  logic [31:0]            out_nonce_q, out_nonce_d;
  logic [31:0]            remaining_q, remaining_d;
  logic [31:0]            core_nonce_q, core_nonce_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [PIPE_LATENCY-1:0] tag_q, tag_d;
  logic                   exit_q, exit_d;
  logic [IW-1:0]          inflight_q, inflight_d;
  logic                   accept, issue, kill, hit, push, pop, full, empty;

  logic [31:0]            fifo_q [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, rd_ptr_q;
  logic [15:0]            dropped_q;
  logic                   unused_hash;

  assign unused_hash = ^core_hash[479:0];

  assign accept = (state_q == StIdle) && bus.work_valid;
  assign kill   = abort && (state_q != StIdle);
  // exit_q lines up with core_hash for the nonce issued PIPE_LATENCY cycles earlier
  assign hit    = exit_q && (core_hash[511:480] <= target_q);

  always_comb begin
    state_d       = state_q;
    issue_nonce_d = issue_nonce_q;
    out_nonce_d   = out_nonce_q;
    remaining_d   = remaining_q;
    core_nonce_d  = core_nonce_q;
    phase_d       = phase_q;
    issue         = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          issue_nonce_d = bus.work_nonce_start;
          out_nonce_d   = bus.work_nonce_start;
          remaining_d   = bus.work_nonce_count;
          phase_d       = '0;
          state_d       = (bus.work_nonce_count == 32'd0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
          if (phase_q == '0) begin
            issue         = 1'b1;
            core_nonce_d  = issue_nonce_q;
            issue_nonce_d = issue_nonce_q + 32'd1;
            remaining_d   = remaining_q - 32'd1;
            if (remaining_q == 32'd1) state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (inflight_q == '0 && !exit_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (exit_q && state_q != StIdle) out_nonce_d = out_nonce_q + 32'd1;

    if (kill) begin
      tag_d      = '0;
      exit_d     = 1'b0;
      inflight_d = '0;
    end else begin
      tag_d      = {tag_q[PIPE_LATENCY-2:0], issue};
      exit_d     = tag_q[PIPE_LATENCY-1];
      inflight_d = inflight_q + IW'(issue) - IW'(exit_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mid_q         <= '0;
      data_q        <= '0;
      target_q      <= '0;
      issue_nonce_q <= '0;
      out_nonce_q   <= '0;
      remaining_q   <= '0;
      core_nonce_q  <= '0;
      phase_q       <= '0;
      tag_q         <= '0;
      exit_q        <= 1'b0;
      inflight_q    <= '0;
    end else begin
      state_q       <= state_d;
      issue_nonce_q <= issue_nonce_d;
      out_nonce_q   <= out_nonce_d;
      remaining_q   <= remaining_d;
      core_nonce_q  <= core_nonce_d;
      phase_q       <= phase_d;
      tag_q         <= tag_d;
      exit_q        <= exit_d;
      inflight_q    <= inflight_d;
      if (accept) begin
        mid_q    <= bus.work_midstate;
        data_q   <= bus.work_data;
        target_q <= bus.work_target;
      end
    end
  end

  // Fullness is judged before any same-cycle pop, so a hit into a full FIFO always drops.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = hit && !full;
  assign pop   = !empty && bus.found_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q[AW-1:0]] <= out_nonce_q;
        wr_ptr_q                 <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (hit && full && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign bus.work_ready  = (state_q == StIdle);
  assign bus.found_valid = !empty;
  assign bus.found_nonce = fifo_q[rd_ptr_q[AW-1:0]];
  assign core_midstate   = mid_q;
  assign core_data       = data_q;
  assign core_nonce      = core_nonce_q;
  assign found_dropped   = dropped_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_skein_nonce_scheduler.sv
// Bench for skein_nonce_scheduler: core stub delays nonce by the pipe latency into hash[511:480];
// an event-list model predicts every output each cycle, and directed cases pin it with literals.
module tb_skein_nonce_scheduler;
  localparam int unsigned L     = 8;
  localparam int unsigned II    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  skein_nonce_scheduler_if bus ();
  logic         abort;
  logic [511:0] core_midstate, core_hash;
  logic [95:0]  core_data;
  logic [31:0]  core_nonce;
  logic [15:0]  found_dropped;
  logic         busy, done;

  skein_nonce_scheduler #(
    .PIPE_LATENCY  (L),
    .ISSUE_INTERVAL(II),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .abort        (abort),
    .core_midstate(core_midstate),
    .core_data    (core_data),
    .core_nonce   (core_nonce),
    .core_hash    (core_hash),
    .found_dropped(found_dropped),
    .busy         (busy),
    .done         (done)
  );

  // Core stub: nonce delayed L cycles appears in the top hash word
  logic [31:0] pipe [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(L); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= core_nonce;
      for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
    end
  end
  assign core_hash = {pipe[L-1], 480'd0};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int          cyc;
    logic [31:0] n;
  } ev_t;

  ev_t          m_issue[$];
  ev_t          m_hit[$];
  logic [31:0]  mq[$];
  logic [31:0]  m_core;
  logic [511:0] m_mid;
  logic [95:0]  m_data;
  int           m_drop;
  bit           m_busy;
  int           m_done_c;
  logic [31:0]  log_q[$];
  int           n_done = 0;
  int           a_m, k_m;
  bit           full_m;
  logic [31:0]  cnt_m, n_m;

  function automatic void model_reset();
    m_issue.delete();
    m_hit.delete();
    mq.delete();
    m_core   = '0;
    m_mid    = '0;
    m_data   = '0;
    m_drop   = 0;
    m_busy   = 1'b0;
    m_done_c = -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_busy", busy, 0);
      chk("rst_work_ready", bus.work_ready, 1);
      chk("rst_found_valid", bus.found_valid, 0);
      chk("rst_dropped", found_dropped, 0);
    end else begin
      chk("busy", busy, m_busy);
      chk("work_ready", bus.work_ready, !m_busy);
      chk("done", done, m_busy && cyc == m_done_c);
      chk("core_nonce", core_nonce, m_core);
      chk("core_midstate", core_midstate, m_mid);
      chk("core_data", core_data, m_data);
      chk("found_valid", bus.found_valid, mq.size() != 0);
      if (mq.size() != 0) chk("found_nonce", bus.found_nonce, mq[0]);
      chk("found_dropped", found_dropped, m_drop);
      if (done) n_done++;
      if (bus.found_valid && bus.found_ready) log_q.push_back(bus.found_nonce);

      // advance model to the coming edge a_m
      a_m = cyc + 1;
      if (m_busy && abort) begin
        m_busy = 1'b0;
        while (m_issue.size() != 0 && m_issue[$].cyc >= a_m) void'(m_issue.pop_back());
        while (m_hit.size() != 0 && m_hit[$].cyc > a_m) void'(m_hit.pop_back());
      end else if (m_busy && cyc == m_done_c) begin
        m_busy = 1'b0;
      end else if (!m_busy && bus.work_valid) begin
        k_m    = a_m;
        m_busy = 1'b1;
        m_mid  = bus.work_midstate;
        m_data = bus.work_data;
        cnt_m  = bus.work_nonce_count;
        for (int i = 0; i < int'(cnt_m); i++) begin
          n_m = bus.work_nonce_start + 32'(i);
          m_issue.push_back('{cyc: k_m + 1 + i * II, n: n_m});
          if (n_m <= bus.work_target) m_hit.push_back('{cyc: k_m + 2 + i * II + L, n: n_m});
        end
        m_done_c = (cnt_m == 0) ? k_m : k_m + (int'(cnt_m) - 1) * II + L + 2;
      end

      full_m = (mq.size() == DEPTH);
      if (mq.size() != 0 && bus.found_ready) void'(mq.pop_front());
      while (m_hit.size() != 0 && m_hit[0].cyc == a_m) begin
        if (full_m) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          mq.push_back(m_hit[0].n);
        end
        void'(m_hit.pop_front());
      end
      while (m_issue.size() != 0 && m_issue[0].cyc == a_m) begin
        m_core = m_issue[0].n;
        void'(m_issue.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] exp_q[$];
  int          d0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] c, input logic [31:0] t);
    bus.work_valid       = 1'b1;
    bus.work_nonce_start = s;
    bus.work_nonce_count = c;
    bus.work_target      = t;
    bus.work_midstate    = {16{s ^ c}};
    bus.work_data        = {3{t}};
    tick();
    bus.work_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk("wait_done", seen, 1);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(name, (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF, exp_q[i]);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.work_valid       = 1'b0;
    bus.work_midstate    = '0;
    bus.work_data        = '0;
    bus.work_nonce_start = '0;
    bus.work_nonce_count = '0;
    bus.work_target      = '0;
    bus.found_ready      = 1'b1;
    abort                = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();

    // 1: two hits out of five
    d0 = n_done;
    send(32'd100, 32'd5, 32'd101);
    wait_done(100);
    repeat (3) tick();
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd101);
    chk_log("t1_found");
    chk("t1_done_once", n_done - d0, 1);
    chk("t1_dropped", found_dropped, 0);

    // 2: nonce range wraps through zero
    send(32'hFFFF_FFFE, 32'd4, 32'hFFFF_FFFF);
    wait_done(100);
    repeat (3) tick();
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    chk_log("t2_found");
    chk("t2_core_nonce", core_nonce, 32'd1);

    // 3: consumer stalled, FIFO overflows
    bus.found_ready = 1'b0;
    send(32'd10, 32'd6, 32'hFFFF_FFFF);
    wait_done(100);
    tick();
    chk("t3_dropped", found_dropped, 2);
    chk("t3_head_valid", bus.found_valid, 1);
    chk("t3_head", bus.found_nonce, 32'd10);
    bus.found_ready = 1'b1;
    repeat (6) tick();
    for (int i = 10; i < 14; i++) exp_q.push_back(32'(i));
    chk_log("t3_found");

    // 4: abort mid-issue, then a clean unit
    d0 = n_done;
    send(32'd50, 32'd100, 32'd0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_ready", bus.work_ready, 1);
    chk("t4_core_nonce", core_nonce, 32'd50);
    repeat (2) tick();
    chk("t4_no_done", n_done - d0, 0);
    send(32'd200, 32'd3, 32'd201);
    wait_done(100);
    repeat (3) tick();
    exp_q.push_back(32'd200);
    exp_q.push_back(32'd201);
    chk_log("t4_found");
    chk("t4_dropped", found_dropped, 2);

    // 5: empty range
    d0 = n_done;
    send(32'd7, 32'd0, 32'd0);
    chk("t5_done", done, 1);
    tick();
    chk("t5_done_gone", done, 0);
    chk("t5_idle", busy, 0);
    chk("t5_core_nonce", core_nonce, 32'd202);
    chk("t5_no_push", bus.found_valid, 0);
    chk("t5_done_once", n_done - d0, 1);

    // 6: reset while draining with two entries queued
    bus.found_ready = 1'b0;
    send(32'd300, 32'd3, 32'hFFFF_FFFF);
    repeat (12) tick();
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_valid", bus.found_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", bus.work_ready, 1);
    chk("t6_done", done, 0);
    chk("t6_valid", bus.found_valid, 0);
    chk("t6_nonce", bus.found_nonce, 0);
    chk("t6_dropped", found_dropped, 0);
    chk("t6_core_nonce", core_nonce, 0);
    chk("t6_core_mid", core_midstate, 0);
    chk("t6_core_data", core_data, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus.found_ready = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

endmodule
